// File: rtl/multicycle_control_unit_if.sv
// Purpose : bundles the instruction-field inputs and every control output of the
//           multi-cycle MIPS control unit into one bus.
// Signals : opcode_in/funct_in (IR fields), zero_in (ALU zero flag) flow into the
//           control unit; datapath mux selects, write enables, ALU op, debug state
//           and the check/illegal pulses flow out of it.
// Modports: master - the control unit (drives the control outputs)
//           slave  - the datapath side (drives IR fields and the zero flag)
interface multicycle_control_unit_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
);
  logic [OPCODE_WIDTH-1:0] opcode_in;
  logic [OPCODE_WIDTH-1:0] funct_in;
  logic                    zero_in;
  logic                    pc_write;
  logic                    i_or_d;
  logic                    mem_write;
  logic                    ir_write;
  logic                    mem_to_reg;
  logic                    reg_dst;
  logic                    reg_write;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [2:0]              alu_control;
  logic [1:0]              pc_src;
  logic                    check_valid;
  logic                    illegal_op;
  logic [STATE_WIDTH-1:0]  state_out;

  modport master (
    input  opcode_in, funct_in, zero_in,
    output pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, check_valid, illegal_op,
           state_out
  );

  modport slave (
    output opcode_in, funct_in, zero_in,
    input  pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, check_valid, illegal_op,
           state_out
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Purpose : Moore-style control FSM for the multi-cycle MIPS datapath. Walks each
//           instruction through fetch, decode, execute, memory and writeback in
//           3-5 cycles and drives the datapath mux selects and write enables.
// Ports   : clk     - rising-edge clock
//           reset_n - synchronous active-low reset; all outputs read 0 while low
//           bus     - control bus (master side): IR opcode/funct and ALU zero in,
//                     PC/memory/IR/register-file controls, ALU op, check and
//                     illegal pulses and the current state out
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_CHECK   = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = OPCODE_WIDTH'(6'b001001);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_CHECK = OPCODE_WIDTH'(6'b111111);

  localparam logic [OPCODE_WIDTH-1:0] FN_ADD = OPCODE_WIDTH'(6'b100000);
  localparam logic [OPCODE_WIDTH-1:0] FN_SUB = OPCODE_WIDTH'(6'b100010);
  localparam logic [OPCODE_WIDTH-1:0] FN_AND = OPCODE_WIDTH'(6'b100100);
  localparam logic [OPCODE_WIDTH-1:0] FN_OR  = OPCODE_WIDTH'(6'b100101);
  localparam logic [OPCODE_WIDTH-1:0] FN_SLT = OPCODE_WIDTH'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t r_state;
  state_t w_next;

  logic       w_pc_write;
  logic       w_i_or_d;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_control;
  logic [1:0] w_pc_src;
  logic       w_check_valid;
  logic       w_illegal_op;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    w_pc_write    = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = 3'b000;
    w_pc_src      = 2'b00;
    w_check_valid = 1'b0;
    w_illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed and loaded while the instruction is latched.
        w_ir_write    = 1'b1;
        w_alu_src_b   = 2'b01;
        w_alu_control = ALU_ADD;
        w_pc_write    = 1'b1;
        w_next        = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) into ALUOut for a possible branch.
        w_alu_src_b   = 2'b11;
        w_alu_control = ALU_ADD;
        case (bus.opcode_in)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDIU:     w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          OP_CHECK:     w_next = S_CHECK;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b10;
        w_alu_control = ALU_ADD;
        w_next        = (bus.opcode_in == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_i_or_d = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_next      = S_ALUWB;
        case (bus.funct_in)
          FN_ADD:  w_alu_control = ALU_ADD;
          FN_SUB:  w_alu_control = ALU_SUB;
          FN_AND:  w_alu_control = ALU_AND;
          FN_OR:   w_alu_control = ALU_OR;
          FN_SLT:  w_alu_control = ALU_SLT;
          // Unknown funct: skip writeback entirely and flag it.
          default: w_next = S_ILLEGAL;
        endcase
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        // Branch target already sits in ALUOut; the subtract sets zero_in.
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'b01;
        w_pc_write    = bus.zero_in;
      end
      S_ADDI_EX: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b10;
        w_alu_control = ALU_ADD;
        w_next        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      S_CHECK: begin
        w_check_valid = 1'b1;
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_ADD;
      end
      S_ILLEGAL: begin
        w_illegal_op = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Reset suppresses every control output in the same cycle, so an
    // instruction caught mid-flight cannot write memory or registers.
    if (!reset_n) begin
      w_pc_write    = 1'b0;
      w_i_or_d      = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_mem_to_reg  = 1'b0;
      w_reg_dst     = 1'b0;
      w_reg_write   = 1'b0;
      w_alu_src_a   = 1'b0;
      w_alu_src_b   = 2'b00;
      w_alu_control = 3'b000;
      w_pc_src      = 2'b00;
      w_check_valid = 1'b0;
      w_illegal_op  = 1'b0;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.i_or_d      = w_i_or_d;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.pc_src      = w_pc_src;
  assign bus.check_valid = w_check_valid;
  assign bus.illegal_op  = w_illegal_op;
  assign bus.state_out   = reset_n ? r_state : S_FETCH;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed instruction sequence followed
// by random instructions, every cycle checked against an instruction-level model.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       check_valid;
    logic       illegal_op;
  } ctl_t;

  localparam logic [5:0] RT = 6'b000000, JJ = 6'b000010, BQ = 6'b000100,
                         AI = 6'b001001, LW = 6'b100011, SW = 6'b101011,
                         CK = 6'b111111;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  ctl_t exp_q[$];

  multicycle_control_unit_if #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) bus ();

  multicycle_control_unit #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t observe();
    ctl_t o;
    o.st          = bus.state_out;
    o.pc_write    = bus.pc_write;
    o.i_or_d      = bus.i_or_d;
    o.mem_write   = bus.mem_write;
    o.ir_write    = bus.ir_write;
    o.mem_to_reg  = bus.mem_to_reg;
    o.reg_dst     = bus.reg_dst;
    o.reg_write   = bus.reg_write;
    o.alu_src_a   = bus.alu_src_a;
    o.alu_src_b   = bus.alu_src_b;
    o.alu_control = bus.alu_control;
    o.pc_src      = bus.pc_src;
    o.check_valid = bus.check_valid;
    o.illegal_op  = bus.illegal_op;
    return o;
  endfunction

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the full per-cycle control trace of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ctl_t c;
    logic [2:0] alu;
    logic fn_ok;
    exp_q.delete();
    c = '0; c.st = 4'd0; c.ir_write = 1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
    c.pc_write = 1; exp_q.push_back(c);
    c = '0; c.st = 4'd1; c.alu_src_b = 2'b11; c.alu_control = 3'b010; exp_q.push_back(c);
    if (op == LW || op == SW) begin
      c = '0; c.st = 4'd2; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
      exp_q.push_back(c);
    end
    case (op)
      LW: begin
        c = '0; c.st = 4'd3; c.i_or_d = 1; exp_q.push_back(c);
        c = '0; c.st = 4'd4; c.mem_to_reg = 1; c.reg_write = 1; exp_q.push_back(c);
      end
      SW: begin
        c = '0; c.st = 4'd5; c.i_or_d = 1; c.mem_write = 1; exp_q.push_back(c);
      end
      RT: begin
        fn_ok = 1'b1;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default: begin alu = 3'b000; fn_ok = 1'b0; end
        endcase
        c = '0; c.st = 4'd6; c.alu_src_a = 1; c.alu_control = alu; exp_q.push_back(c);
        c = '0;
        if (fn_ok) begin c.st = 4'd7; c.reg_dst = 1; c.reg_write = 1; end
        else begin c.st = 4'd13; c.illegal_op = 1; end
        exp_q.push_back(c);
      end
      BQ: begin
        c = '0; c.st = 4'd8; c.alu_src_a = 1; c.alu_control = 3'b110; c.pc_src = 2'b01;
        c.pc_write = z; exp_q.push_back(c);
      end
      AI: begin
        c = '0; c.st = 4'd9; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
        exp_q.push_back(c);
        c = '0; c.st = 4'd10; c.reg_write = 1; exp_q.push_back(c);
      end
      JJ: begin
        c = '0; c.st = 4'd11; c.pc_src = 2'b10; c.pc_write = 1; exp_q.push_back(c);
      end
      CK: begin
        c = '0; c.st = 4'd12; c.check_valid = 1; c.alu_src_a = 1; c.alu_control = 3'b010;
        exp_q.push_back(c);
      end
      default: begin
        c = '0; c.st = 4'd13; c.illegal_op = 1; exp_q.push_back(c);
      end
    endcase
  endtask

  // Called just after a falling edge with the DUT in FETCH; returns likewise.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
    build(op, fn, z);
    bus.opcode_in = op;
    bus.funct_in  = fn;
    bus.zero_in   = z;
    #1;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s c%0d", name, i), observe(), exp_q[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[5];
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t zero_c;
    ctl_t fetch_c;
    total = 0;
    bad   = 0;
    ops = '{RT, RT, JJ, BQ, AI, LW, SW, CK};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    zero_c = '0;

    reset_n       = 1'b0;
    bus.opcode_in = LW;
    bus.funct_in  = 6'b0;
    bus.zero_in   = 1'b0;
    @(negedge clk);
    check("reset0", observe(), zero_c);
    @(negedge clk);
    check("reset1", observe(), zero_c);
    reset_n = 1'b1;

    run_instr("lw", LW, 6'b0, 1'b0);
    run_instr("add", RT, 6'b100000, 1'b0);
    run_instr("sub", RT, 6'b100010, 1'b0);
    run_instr("and", RT, 6'b100100, 1'b0);
    run_instr("or",  RT, 6'b100101, 1'b0);
    run_instr("slt", RT, 6'b101010, 1'b0);
    run_instr("beq_t", BQ, 6'b0, 1'b1);
    run_instr("beq_n", BQ, 6'b0, 1'b0);
    run_instr("sw", SW, 6'b0, 1'b0);
    run_instr("addiu", AI, 6'b0, 1'b0);
    run_instr("j", JJ, 6'b0, 1'b0);
    run_instr("check", CK, 6'b0, 1'b0);
    run_instr("ill_op", 6'b000001, 6'b0, 1'b0);
    run_instr("ill_fn", RT, 6'b000000, 1'b0);

    // Reset asserted in the MEMWR cycle of a store.
    build(SW, 6'b0, 1'b0);
    fetch_c = exp_q[0];
    bus.opcode_in = SW;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("sw_rst c%0d", i), observe(), exp_q[i]);
    end
    reset_n = 1'b0;
    #1;
    check("rst_in_memwr", observe(), zero_c);
    @(negedge clk);
    check("rst_held", observe(), zero_c);
    reset_n = 1'b1;
    #1;
    check("rst_to_fetch", observe(), fetch_c);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
